// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM state type and press-counter width for debounce_pulse.
package debounce_pkg;
   localparam int PRESS_CNT_W = 8;
   typedef enum logic [1:0] {IDLE, CHK_PRESS, PRESSED, CHK_RELEASE} debounce_state_t;
endpackage

// File: rtl/edge_pulse.sv
// edge_pulse: registered one-cycle rise strobe (and fall strobe when DEBOUNCE_RELEASE_PULSE_EN is defined)
// from a level's current registered value and its next value, so strobes line up with the level change.
module edge_pulse (
   input  logic clk,
   input  logic rst,
   input  logic level_d_i,
   input  logic level_q_i,
`ifdef DEBOUNCE_RELEASE_PULSE_EN
   output logic fall_o,
`endif
   output logic rise_o
);
   logic rise_q;
   always_ff @(posedge clk) begin
      if (rst) rise_q <= 1'b0;
      else     rise_q <= level_d_i & ~level_q_i;
   end
   assign rise_o = rise_q;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
   logic fall_q;
   always_ff @(posedge clk) begin
      if (rst) fall_q <= 1'b0;
      else     fall_q <= ~level_d_i & level_q_i;
   end
   assign fall_o = fall_q;
`endif
endmodule

// File: rtl/debounce_pulse.sv
// debounce_pulse: four-state button debouncer with press strobe and wrapping press counter;
// btn_release strobe is built only when DEBOUNCE_RELEASE_PULSE_EN is defined.
module debounce_pulse
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_sync,
   output logic                   btn_level,
   output logic                   btn_pulse,
`ifdef DEBOUNCE_RELEASE_PULSE_EN
   output logic                   btn_release,
`endif
   output logic [PRESS_CNT_W-1:0] press_count
);
   localparam int CW = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
   debounce_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PRESS_CNT_W-1:0] count_q;
   logic lvl_q, lvl_d;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (lvl_d & ~lvl_q) count_q <= count_q + PRESS_CNT_W'(1);
      end
   end
   // The CHK_* states abort back to their stable state on any sample matching the old level.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (in_sync) begin
            state_d = CHK_PRESS;
            cnt_d   = CW'(1);
         end
         CHK_PRESS: if (!in_sync) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else if (cnt_q == LAST) begin
            state_d = PRESSED;
            cnt_d   = '0;
         end else cnt_d = cnt_q + CW'(1);
         PRESSED: if (!in_sync) begin
            state_d = CHK_RELEASE;
            cnt_d   = CW'(1);
         end
         CHK_RELEASE: if (in_sync) begin
            state_d = PRESSED;
            cnt_d   = '0;
         end else if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else cnt_d = cnt_q + CW'(1);
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end
   always_comb begin
      lvl_q       = (state_q == PRESSED) || (state_q == CHK_RELEASE);
      lvl_d       = (state_d == PRESSED) || (state_d == CHK_RELEASE);
      btn_level   = lvl_q;
      press_count = count_q;
   end
   edge_pulse u_edge (
      .clk       (clk),
      .rst       (rst),
      .level_d_i (lvl_d),
      .level_q_i (lvl_q),
`ifdef DEBOUNCE_RELEASE_PULSE_EN
      .fall_o    (btn_release),
`endif
      .rise_o    (btn_pulse)
   );
endmodule
